dbus_sram_responder: RTL

- Responder (slave) end of the core's data-bus request interface: req/we/addr/data/mask in; rdata/ready out.
- Replaces the zero-latency behavioural memory with a synthesizable word-organised SRAM model.
- Adds configurable wait states, a one-cycle ready pulse, byte-masked writes, and error signalling for misaligned or out-of-range accesses.
- Sits between the core's dbus (or ibus) port and on-chip storage.

---
 rtl/dbus_sram_responder_if.sv | 25 ++
 rtl/dbus_sram_responder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/dbus_sram_responder_if.sv
// Data-bus request/response bundle between a core's load/store port and a memory responder.
// The initiator drives the I_* signals; the responder returns the O_* signals.
interface dbus_sram_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    I_req;
    logic                    I_we;
    logic [ADDR_WIDTH-1:0]   I_addr;
    logic [DATA_WIDTH-1:0]   I_data;
    logic [DATA_WIDTH/8-1:0] I_mask;
    logic [DATA_WIDTH-1:0]   O_data;
    logic                    O_ready;
    logic                    O_err;

    modport master (
        output I_req, I_we, I_addr, I_data, I_mask,
        input  O_data, O_ready, O_err
    );

    modport slave (
        input  I_req, I_we, I_addr, I_data, I_mask,
        output O_data, O_ready, O_err
    );
endinterface

// File: rtl/dbus_sram_responder.sv
// Word-organised SRAM responder for the core data bus: captures one request, waits
// WAIT_CYCLES, then answers with a one-cycle registered ready pulse (optionally flagged as error).
module dbus_sram_responder #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH       = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int                    WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    dbus_sram_responder_if.slave  bus
);

    localparam int LP_BYTES = DATA_WIDTH / 8;
    localparam int LP_IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [3:0]              r_cnt;
    logic [3:0]              w_nextCnt;

    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [LP_BYTES-1:0]     r_mask;

    logic                    r_ready;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_rdata;

    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic                    w_we;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [ADDR_WIDTH-1:0]   w_offset;
    logic [ADDR_WIDTH-1:0]   w_word;
    logic [LP_IDX_W-1:0]     w_index;
    logic                    w_legal;

    // In IDLE the live request is decoded (needed when WAIT_CYCLES=0); afterwards the captured one.
    assign w_we     = (r_state == S_IDLE) ? bus.I_we   : r_we;
    assign w_addr   = (r_state == S_IDLE) ? bus.I_addr : r_addr;
    assign w_offset = w_addr - BASE_ADDR;
    assign w_word   = w_offset >> 2;
    assign w_index  = w_word[LP_IDX_W-1:0];
    assign w_legal  = (w_addr >= BASE_ADDR) && (w_word < ADDR_WIDTH'(DEPTH))
                      && (w_addr[1:0] == 2'b00);

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.I_req) begin
                    if (WAIT_CYCLES == 0) begin
                        w_nextState = S_RESP;
                    end else begin
                        w_nextCnt   = 4'(WAIT_CYCLES - 1);
                        w_nextState = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_nextState = S_RESP;
                end else begin
                    w_nextCnt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_mask  <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            if (r_state == S_IDLE && bus.I_req) begin
                r_we    <= bus.I_we;
                r_addr  <= bus.I_addr;
                r_wdata <= bus.I_data;
                r_mask  <= bus.I_mask;
            end
            // Response registers are loaded on the edge entering RESP so outputs stay registered.
            r_ready <= (w_nextState == S_RESP);
            r_err   <= (w_nextState == S_RESP) && !w_legal;
            r_rdata <= ((w_nextState == S_RESP) && w_legal && !w_we) ? r_mem[w_index] : '0;
        end
    end

    // Write commits on the edge leaving RESP; a reset forces IDLE first, so aborted writes never land.
    always_ff @(posedge clk) begin
        if (r_state == S_RESP && r_we && w_legal) begin
            for (int b = 0; b < LP_BYTES; b++) begin
                if (r_mask[b]) begin
                    r_mem[w_index][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.O_ready = r_ready;
    assign bus.O_err   = r_err;
    assign bus.O_data  = r_rdata;

endmodule
